// File: rtl/ddr_rst_sequencer.sv
// System reset sequencer for the DDR build: holds sys_rst until DDR4 calibration and the
// interconnect reset are both stable. Optional soft reset input enabled by DDR_RST_SEQ_SOFT_RST_EN.
module ddr_rst_sequencer #(
  parameter int HOLD_CYCLES   = 16,
  parameter int STABLE_CYCLES = 8,
  parameter int TIMEOUT_W     = 24,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       calib_done,
  input  logic       ic_rstn,
`ifdef DDR_RST_SEQ_SOFT_RST_EN
  input  logic       soft_rst_req,
`endif
  output logic       sys_rst,
  output logic       ddr_ready,
  output logic       timeout_err,
  output logic [7:0] lost_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] calib_sync_q;
  logic [SYNC_STAGES-1:0] icn_sync_q;

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
  logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]             lost_cnt_q, lost_cnt_d;
  logic                   sys_rst_q, ddr_ready_q, timeout_err_q;

  logic                   ok_d;
  logic                   soft_req_d;
  logic [TIMEOUT_W-1:0]   tmo_inc_d;
  logic                   tmo_hit_d;
  logic [7:0]             lost_inc_d;

  // Both status inputs are asynchronous to clk; plain flop chains are enough for level signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      calib_sync_q <= '0;
      icn_sync_q   <= '0;
    end else begin
      calib_sync_q <= {calib_sync_q[SYNC_STAGES-2:0], calib_done};
      icn_sync_q   <= {icn_sync_q[SYNC_STAGES-2:0], ic_rstn};
    end
  end

  assign ok_d = calib_sync_q[SYNC_STAGES-1] & icn_sync_q[SYNC_STAGES-1];

`ifdef DDR_RST_SEQ_SOFT_RST_EN
  assign soft_req_d = soft_rst_req;
`else
  assign soft_req_d = 1'b0;
`endif

  assign tmo_inc_d  = tmo_cnt_q + TIMEOUT_W'(1);
  assign tmo_hit_d  = &tmo_inc_d;
  assign lost_inc_d = (lost_cnt_q == 8'hFF) ? 8'hFF : lost_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stab_cnt_d = stab_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    lost_cnt_d = lost_cnt_q;
    if (soft_req_d) begin
      // Soft reset outranks a same-cycle drop or timeout, so the drop is not counted.
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      stab_cnt_d = '0;
      tmo_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_WAIT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_WAIT: begin
          tmo_cnt_d = tmo_inc_d;
          if (tmo_hit_d) begin
            state_d = ST_ERROR;
          end else if (ok_d) begin
            state_d    = ST_STABLE;
            stab_cnt_d = '0;
          end
        end
        ST_STABLE: begin
          // The timeout keeps running across STABLE->WAIT bounces and beats a completed window.
          tmo_cnt_d = tmo_inc_d;
          if (tmo_hit_d) begin
            state_d = ST_ERROR;
          end else if (!ok_d) begin
            state_d = ST_WAIT;
          end else if (stab_cnt_q == STAB_LAST) begin
            state_d = ST_RUN;
          end else begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
          end
        end
        ST_RUN: begin
          if (!ok_d) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            tmo_cnt_d  = '0;
            lost_cnt_d = lost_inc_d;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      stab_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      lost_cnt_q    <= '0;
      sys_rst_q     <= 1'b1;
      ddr_ready_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      stab_cnt_q    <= stab_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      lost_cnt_q    <= lost_cnt_d;
      sys_rst_q     <= (state_d != ST_RUN);
      ddr_ready_q   <= (state_d == ST_RUN);
      timeout_err_q <= (state_d == ST_ERROR);
    end
  end

  assign sys_rst     = sys_rst_q;
  assign ddr_ready   = ddr_ready_q;
  assign timeout_err = timeout_err_q;
  assign lost_cnt    = lost_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ddr_rst_sequencer.sv
// Bench for ddr_rst_sequencer: a default instance and a TIMEOUT_W=6 instance share stimulus and
// are compared every cycle against a behavioural model, plus directed latency/boundary checks.
module tb_ddr_rst_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int STAB = 8;
  localparam int M_HOLD = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_ERROR = 4;

  logic clk = 1'b0;
  logic rst, calib_done, ic_rstn, soft_rst_req;
  logic       sys_rst0, ddr_ready0, timeout_err0;
  logic [7:0] lost_cnt0;
  logic [2:0] state0;
  logic       sys_rst1, ddr_ready1, timeout_err1;
  logic [7:0] lost_cnt1;
  logic [2:0] state1;

  always #5 clk = ~clk;

  ddr_rst_sequencer u_dut (
    .clk(clk), .rst(rst), .calib_done(calib_done), .ic_rstn(ic_rstn),
`ifdef DDR_RST_SEQ_SOFT_RST_EN
    .soft_rst_req(soft_rst_req),
`endif
    .sys_rst(sys_rst0), .ddr_ready(ddr_ready0), .timeout_err(timeout_err0),
    .lost_cnt(lost_cnt0), .state(state0)
  );

  ddr_rst_sequencer #(.TIMEOUT_W(6)) u_dut_to (
    .clk(clk), .rst(rst), .calib_done(calib_done), .ic_rstn(ic_rstn),
`ifdef DDR_RST_SEQ_SOFT_RST_EN
    .soft_rst_req(soft_rst_req),
`endif
    .sys_rst(sys_rst1), .ddr_ready(ddr_ready1), .timeout_err(timeout_err1),
    .lost_cnt(lost_cnt1), .state(state1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: phase plus counters, indexed by instance.
  int m_st[2], m_hold[2], m_stab[2], m_tmo[2], m_lost[2], m_lim[2];
  bit [SYNC-1:0] m_cs[2];
  bit [SYNC-1:0] m_is[2];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit ok;
    if (rst) begin
      m_st[k] = M_HOLD; m_hold[k] = 0; m_stab[k] = 0; m_tmo[k] = 0; m_lost[k] = 0;
      m_cs[k] = '0; m_is[k] = '0;
      return;
    end
    ok = m_cs[k][SYNC-1] & m_is[k][SYNC-1];
    m_cs[k] = {m_cs[k][SYNC-2:0], calib_done};
    m_is[k] = {m_is[k][SYNC-2:0], ic_rstn};
`ifdef DDR_RST_SEQ_SOFT_RST_EN
    if (soft_rst_req) begin
      m_st[k] = M_HOLD; m_hold[k] = 0; m_stab[k] = 0; m_tmo[k] = 0;
      return;
    end
`endif
    case (m_st[k])
      M_HOLD: begin
        m_hold[k]++;
        if (m_hold[k] == HOLD) begin m_st[k] = M_WAIT; m_hold[k] = 0; end
      end
      M_WAIT, M_STABLE: begin
        m_tmo[k]++;
        if (m_tmo[k] == m_lim[k]) m_st[k] = M_ERROR;
        else if (m_st[k] == M_WAIT) begin
          if (ok) begin m_st[k] = M_STABLE; m_stab[k] = 0; end
        end else if (!ok) m_st[k] = M_WAIT;
        else begin
          m_stab[k]++;
          if (m_stab[k] == STAB) m_st[k] = M_RUN;
        end
      end
      M_RUN: begin
        if (!ok) begin
          m_st[k] = M_HOLD; m_hold[k] = 0; m_tmo[k] = 0;
          m_lost[k] = (m_lost[k] < 255) ? m_lost[k] + 1 : 255;
        end
      end
      default: m_st[k] = M_ERROR;
    endcase
  endtask

  task automatic cmp_all();
    chk("d0_state",   int'(state0),       m_st[0]);
    chk("d0_sys_rst", int'(sys_rst0),     int'(m_st[0] != M_RUN));
    chk("d0_ready",   int'(ddr_ready0),   int'(m_st[0] == M_RUN));
    chk("d0_tmo_err", int'(timeout_err0), int'(m_st[0] == M_ERROR));
    chk("d0_lost",    int'(lost_cnt0),    m_lost[0]);
    chk("d1_state",   int'(state1),       m_st[1]);
    chk("d1_sys_rst", int'(sys_rst1),     int'(m_st[1] != M_RUN));
    chk("d1_ready",   int'(ddr_ready1),   int'(m_st[1] == M_RUN));
    chk("d1_tmo_err", int'(timeout_err1), int'(m_st[1] == M_ERROR));
    chk("d1_lost",    int'(lost_cnt1),    m_lost[1]);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cyc++;
    cmp_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  // After this returns we are in cycle 0: rst is low and not yet sampled.
  task automatic apply_rst();
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ddr_ready0 && n < budget) begin tick(); n++; end
    chk("wait_ready", int'(ddr_ready0), 1);
  endtask

  task automatic drop_icn();
    ic_rstn = 1'b0;
    tick();
    ic_rstn = 1'b1;
    ticks(2);
  endtask

  initial begin
    m_lim[0] = (1 << 24) - 1;
    m_lim[1] = (1 << 6) - 1;
    rst = 1'b1; calib_done = 1'b1; ic_rstn = 1'b1; soft_rst_req = 1'b0;

    // 1: inputs already good before reset release
    apply_rst();
    chk("t1_rst_state", int'(state0), 0);
    chk("t1_rst_sysrst", int'(sys_rst0), 1);
    chk("t1_rst_lost", int'(lost_cnt0), 0);
    tick_to(24);
    chk("t1_c24_sysrst", int'(sys_rst0), 1);
    chk("t1_c24_state", int'(state0), 2);
    tick();
    chk("t1_c25_sysrst", int'(sys_rst0), 0);
    chk("t1_c25_ready", int'(ddr_ready0), 1);
    chk("t1_c25_state", int'(state0), 3);

    // 2: calib_done rises at cycle 100
    calib_done = 1'b0;
    apply_rst();
    tick_to(100);
    calib_done = 1'b1;
    tick_to(110);
    chk("t2_c110_sysrst", int'(sys_rst0), 1);
    tick();
    chk("t2_c111_sysrst", int'(sys_rst0), 0);

    // 3: 3-cycle dropout while in STABLE
    apply_rst();
    tick_to(20);
    chk("t3_c20_state", int'(state0), 2);
    calib_done = 1'b0;
    ticks(3);
    calib_done = 1'b1;
    tick_to(23);
    chk("t3_c23_state", int'(state0), 1);
    tick_to(26);
    chk("t3_c26_state", int'(state0), 2);
    tick_to(33);
    chk("t3_c33_sysrst", int'(sys_rst0), 1);
    tick();
    chk("t3_c34_sysrst", int'(sys_rst0), 0);

    // 3b: bouncing ok never clears the timeout; small instance still expires at cycle 79
    apply_rst();
    while (cyc < 78) begin
      calib_done = ((cyc / 4) % 2 == 0);
      tick();
    end
    chk("t3b_c78_tmo", int'(timeout_err1), 0);
    tick();
    chk("t3b_c79_tmo", int'(timeout_err1), 1);

    // 4: calib_done stuck low
    calib_done = 1'b0;
    apply_rst();
    tick_to(78);
    chk("t4_c78_state", int'(state1), 1);
    tick();
    chk("t4_c79_state", int'(state1), 4);
    chk("t4_c79_tmo", int'(timeout_err1), 1);
    chk("t4_c79_sysrst", int'(sys_rst1), 1);
    chk("t4_c79_ready", int'(ddr_ready1), 0);
    ticks(500);
    calib_done = 1'b1;
    ticks(500);
    chk("t4_stuck_state", int'(state1), 4);
    chk("t4_d0_run", int'(state0), 3);

    // 5: repeated one-cycle ic_rstn drops in RUN
    apply_rst();
    for (int r = 0; r < 300; r++) begin
      wait_ready(100);
      drop_icn();
      if (r == 0) begin
        chk("t5_first_lost", int'(lost_cnt0), 1);
        chk("t5_first_sysrst", int'(sys_rst0), 1);
        chk("t5_first_state", int'(state0), 0);
      end
    end
    wait_ready(100);
    chk("t5_lost_sat", int'(lost_cnt0), 255);

`ifdef DDR_RST_SEQ_SOFT_RST_EN
    // 6: soft reset from ERROR, soft reset racing a drop, rst in STABLE
    calib_done = 1'b0;
    apply_rst();
    tick_to(85);
    chk("t6_err", int'(state1), 4);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("t6_soft_state", int'(state1), 0);
    chk("t6_soft_tmo", int'(timeout_err1), 0);
    calib_done = 1'b1;
    wait_ready(100);
    drop_icn();
    chk("t6_lost1", int'(lost_cnt0), 1);
    wait_ready(100);
    ic_rstn = 1'b0;
    tick();
    ic_rstn = 1'b1;
    tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("t6_race_state", int'(state0), 0);
    chk("t6_race_lost", int'(lost_cnt0), 1);
    begin
      int n = 0;
      while (state0 != 3'd2 && n < 100) begin tick(); n++; end
    end
    chk("t6_in_stable", int'(state0), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_lost", int'(lost_cnt0), 0);
    chk("t6_rst_state", int'(state0), 0);
`endif

    // Randomized: noisy and stuck-low phases, rare resets
    apply_rst();
    for (int i = 0; i < 4000; i++) begin
      bit stuck;
      stuck = ((i / 250) % 3 == 2);
      rst        = ($urandom_range(0, 799) == 0);
      calib_done = stuck ? 1'b0 : ($urandom_range(0, 99) >= 3);
      ic_rstn    = ($urandom_range(0, 99) >= 3);
`ifdef DDR_RST_SEQ_SOFT_RST_EN
      soft_rst_req = ($urandom_range(0, 299) == 0);
`endif
      tick();
    end
    rst = 1'b0; soft_rst_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
